// File: rtl/alu_issue_rf.sv
// Issue/write-back stage around a registered 32-bit ALU, with a 32x32 register file and result forwarding.
// Latency: operands in alu_* one edge after accept, result written to the RF and flags two edges after accept.
// Backpressure: in_ready drops for one cycle when the next instruction reads the register the E-stage instruction produces.
module alu_issue_rf (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic [31:0] alu_data1,
    output logic [31:0] alu_data2,
    output logic [2:0]  alu_ctrl,
    input  logic [31:0] alu_out,
    input  logic        alu_carry,
    input  logic        alu_zero,
    output logic        carry_flag,
    output logic        zero_flag,
    output logic        busy,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    typedef struct packed {
        logic [2:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        imm_sel;
        logic [12:0] imm;
    } instr_t;

    typedef struct packed {
        logic       vld;
        logic [4:0] rd;
        logic       we;
        logic [2:0] op;
    } tag_t;

    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_NOP = 3'b111;
    localparam tag_t       BUBBLE = '{vld: 1'b0, rd: 5'd0, we: 1'b0, op: OP_NOP};

    logic [31:0] rf [32];
    tag_t        e_tag;
    tag_t        w_tag;

    instr_t      ins;
    logic        ins_we;
    logic        hazard;
    logic        accept;
    logic        fwd_ok;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] op_b;

    assign ins    = instr_t'(in_instr);
    assign ins_we = (ins.op <= OP_OR) && (ins.rd != 5'd0);

    // e_tag.we already excludes r0, so r0 readers can never match here.
    assign hazard = e_tag.vld && e_tag.we &&
                    ((ins.rs1 == e_tag.rd) || (!ins.imm_sel && (ins.rs2 == e_tag.rd)));

    assign in_ready = !hazard;
    assign accept   = in_valid && in_ready;
    assign fwd_ok   = w_tag.vld && w_tag.we;

    // Forwarding from alu_out also covers the edge where the same register is being written back.
    always_comb begin
        src_a = rf[ins.rs1];
        if (ins.rs1 == 5'd0) begin
            src_a = '0;
        end else if (fwd_ok && (ins.rs1 == w_tag.rd)) begin
            src_a = alu_out;
        end
    end

    always_comb begin
        src_b = rf[ins.rs2];
        if (ins.rs2 == 5'd0) begin
            src_b = '0;
        end else if (fwd_ok && (ins.rs2 == w_tag.rd)) begin
            src_b = alu_out;
        end
    end

    assign op_b = ins.imm_sel ? {{19{ins.imm[12]}}, ins.imm} : src_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_tag      <= BUBBLE;
            w_tag      <= BUBBLE;
            alu_data1  <= '0;
            alu_data2  <= '0;
            alu_ctrl   <= OP_NOP;
            carry_flag <= 1'b0;
            zero_flag  <= 1'b0;
        end else begin
            w_tag <= e_tag;
            if (accept) begin
                alu_data1 <= src_a;
                alu_data2 <= op_b;
                alu_ctrl  <= ins.op;
                e_tag     <= '{vld: 1'b1, rd: ins.rd, we: ins_we, op: ins.op};
            end else begin
                // Stall or idle: operands hold, the ALU sees a NOP.
                alu_ctrl <= OP_NOP;
                e_tag    <= BUBBLE;
            end
            if (w_tag.vld && (w_tag.op <= OP_SUB)) begin
                carry_flag <= alu_carry;
                zero_flag  <= alu_zero;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else if (w_tag.vld && w_tag.we) begin
            rf[w_tag.rd] <= alu_out;
        end
    end

    assign dbg_data = (dbg_addr == 5'd0) ? '0 : rf[dbg_addr];
    assign busy     = e_tag.vld | w_tag.vld;

endmodule

// File: tb/tb_alu_issue_rf.sv
// Directed bench for alu_issue_rf with a behavioural registered ALU attached.
module tb_alu_issue_rf;

    localparam logic [2:0] ADD = 3'b000;
    localparam logic [2:0] SUB = 3'b001;
    localparam logic [2:0] AND = 3'b010;
    localparam logic [2:0] XOR = 3'b011;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] alu_data1;
    logic [31:0] alu_data2;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_out;
    logic        alu_carry;
    logic        alu_zero;
    logic        carry_flag;
    logic        zero_flag;
    logic        busy;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_issue_rf dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .alu_data1  (alu_data1),
        .alu_data2  (alu_data2),
        .alu_ctrl   (alu_ctrl),
        .alu_out    (alu_out),
        .alu_carry  (alu_carry),
        .alu_zero   (alu_zero),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag),
        .busy       (busy),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    // Registered ALU: carry is carry-out for ADD and borrow for SUB; unknown ops give a|b.
    logic [32:0] alu_nxt;
    always_comb begin
        alu_nxt = {1'b0, alu_data1 | alu_data2};
        case (alu_ctrl)
            3'b000:  alu_nxt = {1'b0, alu_data1} + {1'b0, alu_data2};
            3'b001:  alu_nxt = {1'b0, alu_data1} - {1'b0, alu_data2};
            3'b010:  alu_nxt = {1'b0, alu_data1 & alu_data2};
            3'b011:  alu_nxt = {1'b0, alu_data1 ^ alu_data2};
            default: alu_nxt = {1'b0, alu_data1 | alu_data2};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_out   <= '0;
            alu_carry <= 1'b0;
            alu_zero  <= 1'b0;
        end else begin
            alu_out   <= alu_nxt[31:0];
            alu_carry <= alu_nxt[32];
            alu_zero  <= (alu_nxt[31:0] == 32'd0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [2:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic isel, input logic [12:0] imm);
        return {op, rd, rs1, rs2, isel, imm};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] i);
        in_valid = v;
        in_instr = i;
        #1;
    endtask

    task automatic reg_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
        dbg_addr = a;
        #1;
        chk(tag, dbg_data, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_instr = '0;
        dbg_addr = '0;
        repeat (2) tick;

        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd7);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_carry", 32'(carry_flag), 32'd0);
        chk("rst_zero", 32'(zero_flag), 32'd0);
        chk("rst_data1", alu_data1, 32'd0);
        rst = 1'b0;

        // Reset while ADD r1 = r0 + 5 is in W
        drive(1'b1, mk(ADD, 5'd1, 5'd0, 5'd0, 1'b1, 13'd5));
        tick;
        chk("mf_alu_ctrl", 32'(alu_ctrl), 32'd0);
        chk("mf_data2", alu_data2, 32'd5);
        chk("mf_busy", 32'(busy), 32'd1);
        drive(1'b0, '0);
        tick;
        rst = 1'b1;
        #1;
        chk("mf_rst_alu_ctrl", 32'(alu_ctrl), 32'd7);
        chk("mf_rst_busy", 32'(busy), 32'd0);
        chk("mf_rst_in_ready", 32'(in_ready), 32'd1);
        tick;
        tick;
        rst = 1'b0;
        reg_chk("mf_r1", 5'd1, 32'd0);
        chk("mf_carry", 32'(carry_flag), 32'd0);
        chk("mf_zero", 32'(zero_flag), 32'd0);

        // Independent issue
        drive(1'b1, mk(ADD, 5'd1, 5'd0, 5'd0, 1'b1, 13'd7));
        chk("ind_rdy0", 32'(in_ready), 32'd1);
        tick;
        drive(1'b1, mk(ADD, 5'd2, 5'd0, 5'd0, 1'b1, 13'h1FFF));
        chk("ind_rdy1", 32'(in_ready), 32'd1);
        tick;
        drive(1'b0, '0);
        chk("ind_rdy2", 32'(in_ready), 32'd1);
        tick;
        chk("ind_rdy3", 32'(in_ready), 32'd1);
        tick;
        reg_chk("ind_r1", 5'd1, 32'd7);
        reg_chk("ind_r2", 5'd2, 32'hFFFF_FFFF);

        // Back-to-back dependency through r1
        drive(1'b1, mk(ADD, 5'd1, 5'd1, 5'd0, 1'b1, 13'd3));
        chk("b2b_rdy_add", 32'(in_ready), 32'd1);
        tick;
        drive(1'b1, mk(SUB, 5'd3, 5'd1, 5'd1, 1'b0, 13'd0));
        chk("b2b_stall", 32'(in_ready), 32'd0);
        tick;
        chk("b2b_release", 32'(in_ready), 32'd1);
        chk("b2b_bubble_ctrl", 32'(alu_ctrl), 32'd7);
        chk("b2b_hold_data1", alu_data1, 32'd7);
        chk("b2b_hold_data2", alu_data2, 32'd3);
        tick;
        chk("b2b_fwd_data1", alu_data1, 32'd10);
        chk("b2b_fwd_data2", alu_data2, 32'd10);
        chk("b2b_ctrl_sub", 32'(alu_ctrl), 32'd1);
        drive(1'b0, '0);
        tick;
        tick;
        reg_chk("b2b_r3", 5'd3, 32'd0);
        reg_chk("b2b_r1", 5'd1, 32'd10);
        chk("b2b_zero", 32'(zero_flag), 32'd1);
        chk("b2b_carry", 32'(carry_flag), 32'd0);

        // Distance-2 forward across a NOP
        drive(1'b1, mk(ADD, 5'd4, 5'd0, 5'd0, 1'b1, 13'd12));
        tick;
        drive(1'b1, mk(3'b101, 5'd0, 5'd0, 5'd0, 1'b1, 13'd0));
        chk("d2_rdy_nop", 32'(in_ready), 32'd1);
        tick;
        drive(1'b1, mk(XOR, 5'd5, 5'd4, 5'd4, 1'b0, 13'd0));
        chk("d2_no_stall", 32'(in_ready), 32'd1);
        tick;
        chk("d2_data1", alu_data1, 32'd12);
        chk("d2_data2", alu_data2, 32'd12);
        chk("d2_ctrl", 32'(alu_ctrl), 32'd3);
        drive(1'b0, '0);
        tick;
        tick;
        reg_chk("d2_r5", 5'd5, 32'd0);
        reg_chk("d2_r4", 5'd4, 32'd12);
        chk("d2_zero", 32'(zero_flag), 32'd0);
        chk("d2_carry", 32'(carry_flag), 32'd0);

        // r0 writes and non-writing op 110
        drive(1'b1, mk(ADD, 5'd6, 5'd0, 5'd0, 1'b1, 13'd33));
        tick;
        drive(1'b1, mk(ADD, 5'd0, 5'd0, 5'd0, 1'b1, 13'd9));
        tick;
        drive(1'b1, mk(ADD, 5'd10, 5'd0, 5'd0, 1'b0, 13'd2));
        chk("r0_no_stall", 32'(in_ready), 32'd1);
        drive(1'b1, mk(ADD, 5'd10, 5'd0, 5'd0, 1'b1, 13'd2));
        tick;
        drive(1'b1, mk(ADD, 5'd11, 5'd0, 5'd0, 1'b1, 13'd3));
        chk("r0_rdy_d2", 32'(in_ready), 32'd1);
        tick;
        drive(1'b1, mk(3'b110, 5'd6, 5'd4, 5'd0, 1'b1, 13'd1));
        tick;
        drive(1'b0, '0);
        repeat (3) tick;
        reg_chk("r0_r0", 5'd0, 32'd0);
        reg_chk("r0_r10", 5'd10, 32'd2);
        reg_chk("r0_r11", 5'd11, 32'd3);
        tick;
        reg_chk("nop_r6", 5'd6, 32'd33);

        // Flag capture by SUB, held across AND
        drive(1'b1, mk(SUB, 5'd7, 5'd0, 5'd0, 1'b1, 13'd1));
        tick;
        drive(1'b1, mk(AND, 5'd9, 5'd4, 5'd0, 1'b1, 13'd8));
        tick;
        drive(1'b0, '0);
        tick;
        chk("fc_carry", 32'(carry_flag), 32'd1);
        chk("fc_zero", 32'(zero_flag), 32'd0);
        reg_chk("fc_r7", 5'd7, 32'hFFFF_FFFF);
        tick;
        chk("fc_and_carry", 32'(carry_flag), 32'd1);
        chk("fc_and_zero", 32'(zero_flag), 32'd0);
        reg_chk("fc_r9", 5'd9, 32'd8);
        chk("fc_idle_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_rf.md
# alu_issue_rf

Issue and write-back stage wrapped around the 32-bit registered ALU. Holds the 32×32 register file, decodes a simple three-operand instruction word, and drives registered operands and op code into the ALU. One clock after the ALU registers its result, the stage writes that result back and latches the carry and zero flags. It forwards the ALU result to dependent instructions and stalls the upstream handshake for one cycle on a back-to-back dependency.

## Interface
- No parameters. Data width is fixed at 32 bits and the register count at 32.
- clk  in  1  rising-edge clock, shared with the ALU.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept; a transfer occurs on a rising edge with in_valid && in_ready.
- in_instr  in  32  instruction word with these fields:
  - op = [31:29]
  - rd = [28:24]
  - rs1 = [23:19]
  - rs2 = [18:14]
  - imm_sel = [13]
  - imm = [12:0]
- alu_data1  out  32  registered operand A to the ALU.
- alu_data2  out  32  registered operand B to the ALU.
- alu_ctrl  out  3  registered ALU op code.
- alu_out  in  32  ALU result (registered inside the ALU).
- alu_carry  in  1  ALU carry.
- alu_zero  in  1  ALU zero.
- carry_flag  out  1  latched carry status.
- zero_flag  out  1  latched zero status.
- busy  out  1  E or W stage holds a valid instruction.
- dbg_addr  in  5  debug read address.
- dbg_data  out  32  combinational register read; r0 reads 0.

## Operation
- **Op codes:**
  - 000 = ADD
  - 001 = SUB
  - 010 = AND
  - 011 = XOR
  - 100 = OR
  - 101–111 = NOP: issued, but no write-back and no flag update.
- **Operand B:** imm_sel=1 selects imm sign-extended from bit 12. imm_sel=0 selects the rs2 value.
- **Register r0:**
  - Reads always return 0.
  - Writes to r0 are dropped.
  - r0 is never a forwarding or hazard match.
- **Pipeline tags:**
  - E stage: instruction whose operands sit in alu_* this cycle. Tags are e_valid, e_rd, e_we.
  - W stage: instruction whose result sits on alu_out this cycle. Tags are w_valid, w_rd, w_we, w_op.
  - we = op ≤ 100 and rd ≠ 0.
- **Hazard:** an E-stage match stalls. A match exists when e_valid && e_we and either:
  - rs1 == e_rd, or
  - imm_sel == 0 and rs2 == e_rd.
- **Stall effects:**
  - in_ready = !hazard. It is evaluated from in_instr whether or not in_valid is high.
  - On a stall edge, E becomes a bubble: e_valid=0 and alu_ctrl=3'b111. alu_data1 and alu_data2 hold their values.
- **Operand source for rs1/rs2, by priority:**
  1. 0 if the register is r0.
  2. alu_out if w_valid && w_we && rs == w_rd (forwarding).
  3. Register file content otherwise.
- **Write-back:** on each edge with w_valid && w_we, RF[w_rd] <= alu_out.
- **Flags:** on each edge with w_valid:
  - if w_op ∈ {000, 001}: carry_flag <= alu_carry and zero_flag <= alu_zero.
  - otherwise the flags hold.
- **Pipeline advance per edge:**
  - W tags <= E tags.
  - E tags <= accepted instruction, or a bubble when nothing is accepted.
- **Idle edge** (no transfer, no stall): alu_ctrl <= 3'b111. Operands hold.

## Timing
- Accept at edge N:
  - alu_* valid after edge N.
  - ALU registers the result at edge N+1.
  - RF and flags update at edge N+2.
- Issue rate: one instruction per cycle without dependencies.
- Dependent instruction immediately following its producer:
  - It gets exactly one stall cycle.
  - It is accepted at edge N+2 using the forwarded value.
- Distance 2: forwarded, no stall.
- Distance ≥3: read from the register file.
- Write-back and operand capture on the same edge, same register: the forwarded value wins, so the new value is issued.
- **Reset (asynchronous, at any time, including mid-stall or mid-pipeline):**
  - All RF entries = 0.
  - e_valid = w_valid = 0.
  - alu_data1 = alu_data2 = 0 and alu_ctrl = 3'b111.
  - carry_flag = zero_flag = 0.
  - busy = 0 and in_ready = 1.
  - In-flight instructions are discarded with no write-back.
- After rst deasserts, the first edge may accept an instruction.
- busy = e_valid | w_valid.

## Test plan
- **Reset mid-flight:** issue ADD r1 = r0 + imm 5 and assert rst one cycle later.
  - Required: r1 reads 0, flags are 0, in_ready = 1, alu_ctrl = 111.
- **Independent issue:** after reset, issue ADD r1 = r0 + imm 7, then ADD r2 = r0 + imm −1 (imm = 13'h1FFF).
  - Required: by edge N+3, dbg r1 = 7 and r2 = 32'hFFFFFFFF.
  - Required: in_ready stays 1 throughout.
- **Back-to-back dependency:** r1 = 7, then SUB r3 = r1 − r1 issued directly after ADD r1 = r1 + imm 3.
  - Required: in_ready = 0 for exactly one cycle.
  - Required: the SUB sees r1 = 10 via forwarding.
  - Required: r3 = 0, zero_flag = 1, carry_flag = 0.
- **Distance-2 forward:** ADD r4 = r0 + imm 12, then NOP op 101, then XOR r5 = r4 ^ r4.
  - Required: no stall, alu_data1 = alu_data2 = 12, r5 = 0.
  - Required: flags unchanged by the XOR and the NOP.
- **r0 and NOP writes:**
  - ADD r0 = r0 + imm 9: r0 stays 0 and no stall for a following r0 reader.
  - op 110 with rd = r6: r6 unchanged.
- **Flag capture:** SUB r7 = r0 − imm 1.
  - Required: r7 = 32'hFFFFFFFF, carry_flag = 1, zero_flag = 0.
  - Required: a following AND leaves both flags unchanged.
